bpu_upd_sched: RTL

BPU_UPD_SCHED -- requirements
Module: bpu_upd_sched

---
 rtl/bpu_upd_sched_pkg.sv | 15 +
 rtl/bpu_upd_sched_upd_fifo.sv | 55 +++++
 rtl/bpu_upd_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/bpu_upd_sched_pkg.sv
// Shared constants and FSM encoding for the BPU update scheduler.
// Stands in for the BP_* defines so every file sees one definition.
package bpu_upd_sched_pkg;

  localparam int BP_ADDR_BITS    = 16;
  localparam int BP_ADDR_DEPTH   = 64;
  localparam int Q_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/bpu_upd_sched_upd_fifo.sv
// Generic FIFO holding pending BPU updates; DEPTH must be a power of two >= 2.
// The read side is a combinational view of the head entry.
module upd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/bpu_upd_sched.sv
// Queues EXU branch-resolution updates and issues them to the BPU in order,
// with a fence-style drain handshake and a count of issued allocations.
module bpu_upd_sched
  import bpu_upd_sched_pkg::*;
#(
  parameter  int N_ADDR_BITS = BP_ADDR_BITS,
  parameter  int N_DATA_BITS = 32,
  parameter  int N_ADDR_W    = $clog2(BP_ADDR_DEPTH),
  parameter  int Q_DEPTH     = Q_DEPTH_DEFAULT,
  localparam int CW          = $clog2(Q_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic                   upd_new_pc,
  input  logic                   upd_type,
  input  logic [N_ADDR_W-1:0]    upd_addr,
  input  logic [N_ADDR_BITS-1:0] upd_bp_pc,
  input  logic [N_DATA_BITS-1:0] upd_pc,
  input  logic                   hold,
  input  logic                   drain_req,
  output logic                   drain_ack,
  output logic                   flush_valid,
  output logic                   flush_new_pc,
  output logic                   flush_type,
  output logic [N_ADDR_W-1:0]    flush_addr,
  output logic [N_ADDR_BITS-1:0] flush_bp_pc,
  output logic [N_DATA_BITS-1:0] flush_pc,
  output logic [CW-1:0]          q_count,
  output logic [15:0]            alloc_cnt
);

  localparam int EW = 2 + N_ADDR_W + N_ADDR_BITS + N_DATA_BITS;

  sched_state_e           state_q;
  logic                   enq;
  logic                   deq;
  logic [EW-1:0]          head;
  logic                   head_new_pc;
  logic                   head_type;
  logic [N_ADDR_W-1:0]    head_addr;
  logic [N_ADDR_BITS-1:0] head_bp_pc;
  logic [N_DATA_BITS-1:0] head_pc;
  logic [15:0]            alloc_cnt_q, alloc_cnt_d;

  upd_fifo #(
    .WIDTH (EW),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data ({upd_new_pc, upd_type, upd_addr, upd_bp_pc, upd_pc}),
    .rd_en   (deq),
    .rd_data (head),
    .count   (q_count)
  );

  assign {head_new_pc, head_type, head_addr, head_bp_pc, head_pc} = head;

  // Intake closes as soon as a drain starts, and never relies on a same-cycle dequeue.
  assign upd_ready = (q_count < CW'(Q_DEPTH)) && (state_q == IDLE);
  assign enq       = upd_valid && upd_ready;

  // The BPU always accepts, so every issued cycle is also a dequeue.
  assign flush_valid = (q_count != '0) && !hold && !rst;
  assign deq         = flush_valid;

  always_comb begin
    flush_new_pc = 1'b0;
    flush_type   = 1'b0;
    flush_addr   = '0;
    flush_bp_pc  = '0;
    flush_pc     = '0;
    if (flush_valid) begin
      flush_new_pc = head_new_pc;
      flush_type   = head_type;
      flush_addr   = head_addr;
      flush_bp_pc  = head_bp_pc;
      flush_pc     = head_pc;
    end
    alloc_cnt_d = alloc_cnt_q;
    if (flush_valid && head_new_pc) alloc_cnt_d = alloc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) alloc_cnt_q <= '0;
    else     alloc_cnt_q <= alloc_cnt_d;
  end

  // Drain handshake: an empty queue with nothing arriving skips straight to ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_req) state_q <= (q_count == '0 && !enq) ? ACK : DRAIN;
        end
        DRAIN: begin
          if (!drain_req)          state_q <= IDLE;
          else if (q_count == '0) state_q <= ACK;
        end
        ACK: begin
          if (!drain_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drain_ack = (state_q == ACK);
  assign alloc_cnt = alloc_cnt_q;

endmodule
